// File: rtl/sim_mmio_monitor.sv
// MMIO monitor for the simulation top: console FIFO, tohost exit register, cycle/instret
// counters, run/drain/halt control and watchdog. Define SIM_MON_TRACE_EN for console echo and end-of-run report.
module sim_mmio_monitor #(
  parameter logic [31:0] BASE_ADDR      = 32'h8000_1000,
  parameter int          CON_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 10000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_we,
  input  logic        mem_re,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  input  logic        retire,
  output logic        mem_hit,
  output logic [31:0] mem_rdata,
  output logic        cpu_stall,
  output logic        halt,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] exit_code,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready
);

  localparam int AW = $clog2(CON_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic          WD_EN   = (TIMEOUT_CYCLES != 32'd0);
  localparam logic [31:0]   WD_LAST = 32'(TIMEOUT_CYCLES - 32'd1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t        state_r, state_nx_s;
  logic          halt_r, pass_r, timeout_r;
  logic [31:0]   exit_code_r, cycle_r, instret_r;
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [7:0]    fifo_mem_r [CON_DEPTH];

  logic        hit_s, run_s, full_s, empty_s;
  logic        push_req_s, push_s, pop_s, tohost_s, wd_fire_s, stall_s;
  logic [31:0] rdata_s;
  logic        unused_s;

  assign unused_s = ^mem_addr[1:0];

  assign hit_s   = (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign run_s   = (state_r == ST_RUN);
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

  // Stall decisions use the registered full flag, so a same-cycle pop never frees a slot early.
  assign push_req_s = run_s && hit_s && mem_we && (mem_addr[3:2] == 2'd1) && mem_wstrb[0];
  assign push_s     = push_req_s && !full_s;
  assign pop_s      = !empty_s && con_ready;
  assign tohost_s   = run_s && hit_s && mem_we && (mem_addr[3:2] == 2'd0) &&
                      (mem_wstrb == 4'hF) && mem_wdata[0];
  assign wd_fire_s  = WD_EN && run_s && (cycle_r == WD_LAST);

  // Load data mux for the four window registers.
  always_comb begin
    rdata_s = 32'd0;
    if (hit_s && mem_re) begin
      case (mem_addr[3:2])
        2'd0:    rdata_s = {exit_code_r[30:0], halt_r};
        2'd1:    rdata_s = {31'd0, full_s};
        2'd2:    rdata_s = cycle_r;
        2'd3:    rdata_s = instret_r;
        default: rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  // Next-state and stall logic; a tohost write wins over a coincident watchdog expiry.
  always_comb begin
    state_nx_s = state_r;
    stall_s    = 1'b0;
    case (state_r)
      ST_RUN: begin
        stall_s = push_req_s && full_s;
        if (tohost_s) begin
          state_nx_s = ST_DRAIN;
        end else if (wd_fire_s) begin
          state_nx_s = ST_HALT;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        stall_s = 1'b1;
        if (empty_s) begin
          state_nx_s = ST_HALT;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      ST_HALT: begin
        stall_s    = 1'b1;
        state_nx_s = ST_HALT;
      end
      default: begin
        stall_s    = 1'b1;
        state_nx_s = ST_RUN;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Status, counters and FIFO pointers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      halt_r      <= 1'b0;
      pass_r      <= 1'b0;
      timeout_r   <= 1'b0;
      exit_code_r <= 32'd0;
      cycle_r     <= 32'd0;
      instret_r   <= 32'd0;
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
    end else begin
      halt_r <= (state_r == ST_HALT);
      if (run_s) begin
        cycle_r <= cycle_r + 32'd1;
      end
      if (run_s && retire) begin
        instret_r <= instret_r + 32'd1;
      end
      if (tohost_s) begin
        exit_code_r <= {1'b0, mem_wdata[31:1]};
        pass_r      <= (mem_wdata[31:1] == 31'd0);
      end else if (wd_fire_s) begin
        exit_code_r <= 32'hFFFF_FFFF;
        pass_r      <= 1'b0;
        timeout_r   <= 1'b1;
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Console byte storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r[AW-1:0]] <= mem_wdata[7:0];
    end
  end

`ifdef SIM_MON_TRACE_EN
  logic fin_pend_r;

  // Console echo and end-of-run report, finishing the simulation one cycle after HALT entry.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fin_pend_r <= 1'b0;
    end else begin
      if (pop_s) begin
        $write("%c", con_data);
      end
      if ((state_r != ST_HALT) && (state_nx_s == ST_HALT)) begin
        if (state_r == ST_RUN) begin
          $display("TIMEOUT cycles=%0d instret=%0d", cycle_r, instret_r);
        end else if (pass_r) begin
          $display("PASS cycles=%0d instret=%0d", cycle_r, instret_r);
        end else begin
          $display("FAIL code=%0d cycles=%0d instret=%0d", exit_code_r, cycle_r, instret_r);
        end
        fin_pend_r <= 1'b1;
      end
      if (fin_pend_r) begin
        $finish;
      end
    end
  end
`else
  // Trace output is not built; the surrounding bench polls halt.
`endif

  assign mem_hit   = hit_s;
  assign mem_rdata = rdata_s;
  assign cpu_stall = stall_s;
  assign halt      = halt_r;
  assign pass      = pass_r;
  assign timeout   = timeout_r;
  assign exit_code = exit_code_r;
  assign con_valid = !empty_s;
  assign con_data  = fifo_mem_r[rd_ptr_r[AW-1:0]];

endmodule

// File: tb/tb_sim_mmio_monitor.sv
// Self-checking bench for sim_mmio_monitor: console bytes are scoreboarded through a queue,
// register reads, stall, drain, exit and watchdog behaviour are checked against fixed expectations.
module tb_sim_mmio_monitor;

  localparam logic [31:0] BASE = 32'h8000_1000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        mem_we = 1'b0;
  logic        mem_re = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [3:0]  mem_wstrb = 4'd0;
  logic        retire = 1'b0;
  logic        con_ready = 1'b0;
  logic        mem_hit, cpu_stall, halt, pass, timeout, con_valid;
  logic [31:0] mem_rdata, exit_code;
  logic [7:0]  con_data;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  sim_mmio_monitor #(
    .BASE_ADDR(BASE),
    .CON_DEPTH(4),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .rstn(rstn), .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .retire(retire), .mem_hit(mem_hit),
    .mem_rdata(mem_rdata), .cpu_stall(cpu_stall), .halt(halt), .pass(pass),
    .timeout(timeout), .exit_code(exit_code), .con_valid(con_valid),
    .con_data(con_data), .con_ready(con_ready)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Console scoreboard: every byte the DUT hands over must match the oldest expected byte.
  always @(negedge clk) begin
    if (rstn && con_valid && con_ready) begin
      if (exp_q.size() == 0) begin
        chk("con_extra_byte", 32'(exp_q.size()), 32'd1);
      end else begin
        chk("con_data", {24'd0, con_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; mem_we = 1'b0; mem_re = 1'b0; retire = 1'b0; con_ready = 1'b0;
    mem_addr = 32'd0; mem_wdata = 32'd0; mem_wstrb = 4'd0;
    exp_q.delete();
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int guard = 0;
    mem_we = 1'b1; mem_addr = addr; mem_wdata = data; mem_wstrb = strb;
    #1;
    while (cpu_stall && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) chk("store_stall_bound", 32'(guard), 32'd0);
    step();
    mem_we = 1'b0; mem_wstrb = 4'd0;
    #1;
  endtask

  task automatic con_put(input logic [7:0] b);
    exp_q.push_back(b);
    store(BASE + 32'h4, {24'd0, b}, 4'h1);
  endtask

  task automatic load_chk(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp_data, input logic exp_hit);
    mem_re = 1'b1; mem_addr = addr;
    #1;
    chk({tag, "_data"}, mem_rdata, exp_data);
    chk({tag, "_hit"}, {31'd0, mem_hit}, {31'd0, exp_hit});
    mem_re = 1'b0;
  endtask

  task automatic wait_halt(input int budget, output int n);
    n = 0;
    while (!halt && n < budget) begin
      step();
      n++;
    end
    if (!halt) chk("halt_wait", {31'd0, halt}, 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    logic [4:0] pat;

    // Reset values.
    do_reset();
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_con_valid", {31'd0, con_valid}, 32'd0);
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_exit_code", exit_code, 32'd0);
    load_chk("rst_cycle", BASE + 32'h8, 32'd0, 1'b1);

    // Counters: 5 run cycles, 3 retirements.
    do_reset();
    pat = 5'b01011;
    for (int i = 0; i < 5; i++) begin
      retire = pat[i];
      step();
    end
    retire = 1'b0;
    load_chk("cnt_cycle", 32'h8000_1008, 32'd5, 1'b1);
    load_chk("cnt_instret", 32'h8000_100C, 32'd3, 1'b1);
    load_chk("cnt_lowbits", 32'h8000_100B, 32'd5, 1'b1);
    load_chk("miss", 32'h8000_2008, 32'd0, 1'b0);
    load_chk("tohost_idle", 32'h8000_1000, 32'd0, 1'b1);
    load_chk("con_not_full", 32'h8000_1004, 32'd0, 1'b1);

    // Console in-order delivery with consumer always ready.
    do_reset();
    con_ready = 1'b1;
    con_put(8'h48);
    con_put(8'h69);
    wait_drain(10);
    step();
    chk("hi_con_valid", {31'd0, con_valid}, 32'd0);

    // FIFO full stall and release.
    do_reset();
    for (int i = 0; i < 4; i++) con_put(8'h30 + 8'(i));
    load_chk("full_flag", BASE + 32'h4, 32'd1, 1'b1);
    exp_q.push_back(8'h34);
    mem_we = 1'b1; mem_addr = BASE + 32'h4; mem_wdata = 32'h34; mem_wstrb = 4'h1;
    #1;
    chk("stall_full", {31'd0, cpu_stall}, 32'd1);
    step();
    chk("stall_hold", {31'd0, cpu_stall}, 32'd1);
    con_ready = 1'b1;
    #1;
    chk("stall_pop_same_cycle", {31'd0, cpu_stall}, 32'd1);
    step();
    chk("stall_release", {31'd0, cpu_stall}, 32'd0);
    step();
    mem_we = 1'b0; mem_wstrb = 4'd0;
    wait_drain(20);
    chk("full_con_valid_end", {31'd0, con_valid}, 32'd0);

    // Drain then halt with pass.
    do_reset();
    con_put(8'h61); con_put(8'h62); con_put(8'h63);
    store(BASE, 32'h1, 4'hF);
    chk("drain_stall", {31'd0, cpu_stall}, 32'd1);
    chk("drain_halt0", {31'd0, halt}, 32'd0);
    step(); step();
    chk("drain_halt_hold", {31'd0, halt}, 32'd0);
    con_ready = 1'b1;
    wait_halt(20, n);
    chk("drain_pass", {31'd0, pass}, 32'd1);
    chk("drain_exit", exit_code, 32'd0);
    chk("drain_timeout", {31'd0, timeout}, 32'd0);
    chk("drain_q", 32'(exp_q.size()), 32'd0);
    load_chk("drain_cycle_frozen", BASE + 32'h8, 32'd4, 1'b1);

    // Ignored tohost writes, then a failing exit code.
    do_reset();
    store(BASE, 32'h6, 4'hF);
    chk("ign_bit0_stall", {31'd0, cpu_stall}, 32'd0);
    store(BASE, 32'h7, 4'h3);
    chk("ign_strb_stall", {31'd0, cpu_stall}, 32'd0);
    load_chk("ign_tohost", BASE, 32'd0, 1'b1);
    store(BASE, 32'h7, 4'hF);
    chk("fail_stall", {31'd0, cpu_stall}, 32'd1);
    chk("fail_exit", exit_code, 32'd3);
    chk("fail_pass", {31'd0, pass}, 32'd0);
    wait_halt(10, n);
    chk("fail_timeout", {31'd0, timeout}, 32'd0);
    load_chk("fail_tohost_rd", BASE, 32'h7, 1'b1);

    // Watchdog with bytes still pending, then mid-operation reset.
    do_reset();
    con_put(8'hA1); con_put(8'hA2);
    wait_halt(40, n);
    chk("wd_halt_cycle", 32'(n + 2), 32'd21);
    chk("wd_timeout", {31'd0, timeout}, 32'd1);
    chk("wd_exit", exit_code, 32'hFFFF_FFFF);
    chk("wd_pass", {31'd0, pass}, 32'd0);
    chk("wd_stall", {31'd0, cpu_stall}, 32'd1);
    chk("wd_con_valid", {31'd0, con_valid}, 32'd1);
    load_chk("wd_cycle", BASE + 32'h8, 32'd20, 1'b1);
    con_ready = 1'b1;
    wait_drain(10);
    rstn = 1'b0;
    step();
    chk("mid_rst_halt", {31'd0, halt}, 32'd0);
    chk("mid_rst_timeout", {31'd0, timeout}, 32'd0);
    chk("mid_rst_exit", exit_code, 32'd0);
    chk("mid_rst_stall", {31'd0, cpu_stall}, 32'd0);
    load_chk("mid_rst_cycle", BASE + 32'h8, 32'd0, 1'b1);
    rstn = 1'b1;

    // Reset discards pending console bytes.
    do_reset();
    con_put(8'h11); con_put(8'h22);
    rstn = 1'b0;
    exp_q.delete();
    step();
    chk("rst_discard_valid", {31'd0, con_valid}, 32'd0);
    rstn = 1'b1;

    // Tohost write coinciding with watchdog expiry wins.
    do_reset();
    for (int i = 0; i < 19; i++) step();
    store(BASE, 32'h1, 4'hF);
    wait_halt(10, n);
    chk("prio_timeout", {31'd0, timeout}, 32'd0);
    chk("prio_pass", {31'd0, pass}, 32'd1);
    chk("prio_exit", exit_code, 32'd0);
    load_chk("prio_cycle", BASE + 32'h8, 32'd20, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sim_mmio_monitor.md
Name: sim_mmio_monitor

Overview:
- Simulation-side MMIO peripheral that sits on the CPU data-memory bus next to single_cycle_cpu inside the sim top.
- Consumes the CPU's loads and stores to a reserved address window:
  - console byte output through a small FIFO;
  - tohost exit/pass-fail register;
  - readable cycle and instret counters.
- Owns the run/halt state machine and the timeout watchdog, which replace ad-hoc counters and timeouts in the testbench.

Parameters:
- BASE_ADDR, 32'h8000_1000, base of 16-byte MMIO window; word-aligned offsets 0x0 tohost, 0x4 console, 0x8 cycle, 0xC instret.
- CON_DEPTH, 4, console FIFO depth in bytes; power of two, at least 2.
- TIMEOUT_CYCLES, 10000, number of RUN cycles before forced halt; 0 disables the watchdog.

Ports:
- clk  input  1  clock.
- rstn  input  1  reset.
- mem_we  input  1  store valid this cycle.
- mem_re  input  1  load valid this cycle.
- mem_addr  input  32  byte address.
- mem_wdata  input  32  store data.
- mem_wstrb  input  4  byte enables.
- retire  input  1  one pulse per retired instruction.
- mem_hit  output  1  address is in window (combinational).
- mem_rdata  output  32  load data (combinational).
- cpu_stall  output  1  CPU must hold the current instruction.
- halt  output  1  simulation finished (sticky).
- pass  output  1  exit code was 0 (valid when halt=1).
- timeout  output  1  halt caused by the watchdog.
- exit_code  output  32  program exit code.
- con_valid  output  1  console byte available.
- con_data  output  8  console byte.
- con_ready  input  1  consumer accepts byte.

Behaviour:
- Reset: rstn, synchronous, active-low; clock clk. Reset values:
  - state=RUN;
  - all counters 0;
  - FIFO empty;
  - halt, pass, timeout, con_valid, cpu_stall all 0;
  - exit_code 0.
- A reset asserted mid-operation, in any state, returns to these values on the next edge and discards FIFO contents.
- Decode: hit = mem_addr[31:4]==BASE_ADDR[31:4]. mem_addr[1:0] is ignored. Accesses outside the window are ignored entirely.
- Reads (combinational, 0-cycle latency):
  - offset 0x0 returns {exit_code[30:0], halt};
  - offset 0x4 returns {31'b0, fifo_full};
  - offset 0x8 returns the cycle counter;
  - offset 0xC returns the instret counter;
  - mem_rdata=0 when not hit.
- Counters (32-bit, wrap mod 2^32):
  - cycle increments every clock while state=RUN;
  - instret increments on each cycle with retire=1 while state=RUN;
  - both are frozen in DRAIN and HALT.
- Console:
  - a store to 0x4 with mem_wstrb[0]=1 pushes mem_wdata[7:0];
  - if the FIFO is full, cpu_stall=1 combinationally in that cycle and no push occurs; the CPU re-presents the store;
  - pop occurs when con_valid && con_ready; con_valid = !empty;
  - when full and a pop occurs in the same cycle, the push is still refused (stall is based on the registered full flag);
  - when not full, a simultaneous push and pop keep the count unchanged.
  - Bytes are delivered strictly in order.
- Tohost:
  - a store to 0x0 with mem_wstrb==4'hF and mem_wdata[0]=1 latches exit_code = mem_wdata>>1 and pass=(exit_code==0), then moves to DRAIN;
  - a store with bit0=0 or a partial strobe is ignored.
- State machine:
  - RUN → DRAIN on a valid tohost write.
  - RUN → HALT on the watchdog: cycle==TIMEOUT_CYCLES-1 while in RUN, with TIMEOUT_CYCLES≠0. On this transition: timeout=1, exit_code=32'hFFFF_FFFF, pass=0, and FIFO contents remain drainable.
  - A tohost write in the same cycle as watchdog expiry takes priority; timeout stays 0.
  - DRAIN → HALT when the FIFO is empty (can be the next cycle).
  - In DRAIN and HALT, cpu_stall=1 constantly, so the CPU makes no further progress.
  - HALT is absorbing until reset. halt is registered and asserts on the cycle after entering HALT.
- Register widths: FIFO pointers are log2(CON_DEPTH)+1 bits, with full/empty derived from the MSB compare.

Optional Feature:
- SIM_MON_TRACE_EN.
- Defined:
  - each popped console byte is printed with $write("%c");
  - on entering HALT, prints "PASS"/"FAIL code=<exit_code>"/"TIMEOUT" plus cycle and instret counts, then calls $finish after 1 further cycle.
- Undefined: no system tasks are compiled; behaviour is otherwise identical, and the bench polls halt.

Test Plan:
- Reset, then 5 cycles with retire=1 on 3 of them; load 0x8000_1008 → 5 and load 0x8000_100C → 3; mem_hit=1 on both.
- Store 'H','i' to 0x8000_1004 with con_ready=1 → con_data 0x48 then 0x69 in order, con_valid deasserts after 2 pops.
- con_ready=0, 5 console stores with CON_DEPTH=4 → 5th store sees cpu_stall=1; raise con_ready → 5th byte accepted next cycle, all 5 bytes delivered in order.
- 3 bytes pending with con_ready=0, then store 32'h1 to 0x8000_1000 → DRAIN with cpu_stall=1 and halt=0; raise con_ready → halt=1 one cycle after the FIFO empties, pass=1, exit_code=0.
- Store 32'h7 to tohost → exit_code=3, pass=0. Store 32'h6 or wstrb=4'h3 → ignored, stays RUN.
- TIMEOUT_CYCLES=20, no tohost write → halt=1 at cycle 21 with timeout=1 and exit_code=32'hFFFF_FFFF; assert rstn=0 for 1 cycle → all outputs return to 0.
